// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: opcodes, FSM states
// and small opcode decode helpers.
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negation for two WIDTH-bit lanes and one
// 2*WIDTH-bit lane; gives |x| on operand entry and applies result signs in FIX.
module muldiv_signfix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic               neg_a,
  input  logic [WIDTH-1:0]   b,
  input  logic               neg_b,
  input  logic [2*WIDTH-1:0] w,
  input  logic               neg_w,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  output logic [2*WIDTH-1:0] w_out
);

  assign a_out = neg_a ? -a : a;
  assign b_out = neg_b ? -b : b;
  assign w_out = neg_w ? -w : w;

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative radix-2 multiply / restoring divide unit for the EX stage, writing HI/LO.
// Optional MULDIV_EARLY_TERM_EN: multiply leaves RUN once remaining multiplier bits are zero.
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e             state;
  logic [CW-1:0]      count;
  logic               is_div_q;
  logic               neg_a_q;
  logic               neg_b_q;
  logic [WIDTH-1:0]   rs_q;
  logic [WIDTH-1:0]   opb;
  logic [2*WIDTH-1:0] opa_sh;
  logic [2*WIDTH-1:0] acc;

  logic               in_idle;
  logic [WIDTH-1:0]   sf_a, sf_b, sf_a_out, sf_b_out;
  logic               sf_neg_a, sf_neg_b, sf_neg_w;
  logic [2*WIDTH-1:0] sf_w_out;

  logic [2*WIDTH-1:0] mul_sum;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
  logic               last_step;

  assign in_idle = (state == S_IDLE);

  // One sign unit shared: operand magnitudes while idle, result signs in FIX.
  always_comb begin
    sf_a     = acc[WIDTH-1:0];
    sf_b     = acc[2*WIDTH-1:WIDTH];
    sf_neg_a = neg_a_q ^ neg_b_q;
    sf_neg_b = neg_a_q;
    sf_neg_w = neg_a_q ^ neg_b_q;
    if (in_idle) begin
      sf_a     = rs_data;
      sf_b     = rt_data;
      sf_neg_a = op_is_signed(op) & rs_data[WIDTH-1];
      sf_neg_b = op_is_signed(op) & rt_data[WIDTH-1];
    end
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .a     (sf_a),
    .neg_a (sf_neg_a),
    .b     (sf_b),
    .neg_b (sf_neg_b),
    .w     (acc),
    .neg_w (sf_neg_w),
    .a_out (sf_a_out),
    .b_out (sf_b_out),
    .w_out (sf_w_out)
  );

  // acc holds the product for multiply, and {remainder, dividend/quotient} for divide.
  always_comb begin
    mul_sum   = acc + (opb[0] ? opa_sh : '0);
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
    if (!div_trial[WIDTH])
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      div_next = {acc[2*WIDTH-2:0], 1'b0};
`ifdef MULDIV_EARLY_TERM_EN
    last_step = (count == CW'(1)) || (!is_div_q && (opb[WIDTH-1:1] == '0));
`else
    last_step = (count == CW'(1));
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      count       <= '0;
      is_div_q    <= 1'b0;
      neg_a_q     <= 1'b0;
      neg_b_q     <= 1'b0;
      rs_q        <= '0;
      opb         <= '0;
      opa_sh      <= '0;
      acc         <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_RUN;
            count    <= CW'(WIDTH);
            is_div_q <= op_is_div(op);
            neg_a_q  <= sf_neg_a;
            neg_b_q  <= sf_neg_b;
            rs_q     <= rs_data;
            opa_sh   <= {{WIDTH{1'b0}}, sf_a_out};
            opb      <= sf_b_out;
            acc      <= op_is_div(op) ? {{WIDTH{1'b0}}, sf_a_out} : '0;
          end
        end
        S_RUN: begin
          count <= count - 1'b1;
          if (is_div_q) begin
            acc <= div_next;
          end else begin
            acc    <= mul_sum;
            opa_sh <= opa_sh << 1;
            opb    <= opb >> 1;
          end
          if (last_step)
            state <= S_FIX;
        end
        S_FIX: begin
          state <= S_DONE;
          done  <= 1'b1;
          if (is_div_q) begin
            if (opb == '0) begin
              hi          <= rs_q;
              lo          <= '1;
              div_by_zero <= 1'b1;
            end else begin
              hi <= sf_b_out;
              lo <= sf_a_out;
            end
          end else begin
            {hi, lo} <= sf_w_out;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state == S_RUN) || (state == S_FIX);
  assign stall = reset && ((in_idle && start) || busy);

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit (default build, optional
// MULDIV_EARLY_TERM_EN latency expectations selected at compile time).
module tb_ex_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;
`ifdef MULDIV_EARLY_TERM_EN
  localparam int LAT_5X1  = 3;
  localparam int LAT_3X12 = 6;
`else
  localparam int LAT_5X1  = W + 2;
  localparam int LAT_3X12 = W + 2;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] rs_data;
  logic [W-1:0] rt_data;
  logic         stall;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int tests = 0;
  int fails = 0;

  ex_muldiv_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Issues one op at posedge+1, holds start until done, returns results and edge count.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit toggle, output logic [W-1:0] rhi, output logic [W-1:0] rlo,
                        output logic rdbz, output int cycles, output bit stall_ok);
    start   = 1'b1;
    op      = o;
    rs_data = a;
    rt_data = b;
    cycles  = 0;
    stall_ok = 1'b1;
    #1;
    while (done !== 1'b1 && cycles < 200) begin
      if (stall !== 1'b1) stall_ok = 1'b0;
      @(posedge clk); #1;
      cycles++;
      if (toggle && cycles == 3) begin
        rs_data = ~a;
        rt_data = a ^ b ^ 32'h5A5A_1234;
        op      = ~o;
      end
    end
    if (stall !== 1'b0) stall_ok = 1'b0;
    rhi  = hi;
    rlo  = lo;
    rdbz = div_by_zero;
    start   = 1'b0;
    op      = 2'b00;
    rs_data = '0;
    rt_data = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 2'b00; rs_data = '0; rt_data = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({stall, busy, done, div_by_zero, hi, lo} !== '0) begin
      fails++;
      $display("FAIL reset_state: got stall=%b busy=%b done=%b dbz=%b hi=%h lo=%h required all 0",
               stall, busy, done, div_by_zero, hi, lo);
    end
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_multu_max();
    logic [W-1:0] rh, rl; logic rd; int cyc; bit sok;
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== 64'hFFFF_FFFE_0000_0001) begin
      fails++; $display("FAIL multu_max: got %h_%h required fffffffe_00000001", rh, rl);
    end
    tests++;
    if (cyc !== W + 2) begin
      fails++; $display("FAIL multu_latency: got %0d required %0d", cyc, W + 2);
    end
    tests++;
    if (sok !== 1'b1) begin
      fails++; $display("FAIL multu_stall_profile: got %b required 1", sok);
    end
    tests++;
    if (rd !== 1'b0) begin
      fails++; $display("FAIL multu_dbz: got %b required 0", rd);
    end
    tests++;
    if ({done, busy} !== 2'b00) begin
      fails++; $display("FAIL done_pulse_width: got done=%b busy=%b required 0 0", done, busy);
    end
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFE_0000_0001) begin
      fails++; $display("FAIL hilo_hold: got %h_%h required fffffffe_00000001", hi, lo);
    end
  endtask

  task automatic test_signed();
    logic [W-1:0] rh, rl; logic rd; int cyc; bit sok;
    run_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
      fails++; $display("FAIL mult_neg7x3: got %h_%h required ffffffff_ffffffeb", rh, rl);
    end
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFFD) begin
      fails++; $display("FAIL div_neg7_2: got hi=%h lo=%h required hi=ffffffff lo=fffffffd", rh, rl);
    end
    run_op(OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== 64'h0000_0001_FFFF_FFFD) begin
      fails++; $display("FAIL div_7_neg2: got hi=%h lo=%h required hi=00000001 lo=fffffffd", rh, rl);
    end
    tests++;
    if (cyc !== W + 2) begin
      fails++; $display("FAIL div_latency: got %0d required %0d", cyc, W + 2);
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] rh, rl; logic rd; int cyc; bit sok;
    run_op(OP_DIVU, 32'd100, 32'd0, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rd, rh, rl} !== {1'b1, 32'd100, 32'hFFFF_FFFF}) begin
      fails++; $display("FAIL divu_by_zero: got dbz=%b hi=%h lo=%h required dbz=1 hi=00000064 lo=ffffffff",
                        rd, rh, rl);
    end
    tests++;
    if (cyc !== W + 2 || sok !== 1'b1) begin
      fails++; $display("FAIL divz_timing: got cycles=%0d stall_ok=%b required %0d 1", cyc, sok, W + 2);
    end
    tests++;
    if (div_by_zero !== 1'b0) begin
      fails++; $display("FAIL divz_pulse: got %b required 0", div_by_zero);
    end
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rd, rh, rl} !== {1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF}) begin
      fails++; $display("FAIL div_signed_by_zero: got dbz=%b hi=%h lo=%h required dbz=1 hi=fffffffb lo=ffffffff",
                        rd, rh, rl);
    end
  endtask

  task automatic test_div_boundary();
    logic [W-1:0] rh, rl; logic rd; int cyc; bit sok;
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rd, rh, rl} !== {1'b0, 32'h0, 32'h8000_0000}) begin
      fails++; $display("FAIL div_overflow: got dbz=%b hi=%h lo=%h required dbz=0 hi=00000000 lo=80000000",
                        rd, rh, rl);
    end
    run_op(OP_DIVU, 32'd7, 32'd9, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== {32'd7, 32'd0}) begin
      fails++; $display("FAIL divu_7_9: got hi=%h lo=%h required hi=00000007 lo=00000000", rh, rl);
    end
    run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd10, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== {32'd5, 32'h1999_9999}) begin
      fails++; $display("FAIL divu_max_10: got hi=%h lo=%h required hi=00000005 lo=19999999", rh, rl);
    end
  endtask

  task automatic test_reset_midrun();
    logic [W-1:0] rh, rl; logic rd; int cyc; bit sok;
    start = 1'b1; op = OP_MULTU; rs_data = 32'hFFFF_FFFF; rt_data = 32'hFFFF_FFFF;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if ({stall, busy} !== 2'b11) begin
      fails++; $display("FAIL midrun_busy: got stall=%b busy=%b required 1 1", stall, busy);
    end
    reset = 1'b0;
    #1;
    tests++;
    if ({stall, busy, done, div_by_zero, hi, lo} !== '0) begin
      fails++; $display("FAIL midrun_reset: got stall=%b busy=%b done=%b dbz=%b hi=%h lo=%h required all 0",
                        stall, busy, done, div_by_zero, hi, lo);
    end
    start = 1'b0;
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    run_op(OP_MULTU, 32'h1234_5678, 32'h0000_0010, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== 64'h0000_0001_2345_6780 || cyc !== W + 2) begin
      fails++; $display("FAIL after_reset_op: got %h_%h in %0d cycles required 00000001_23456780 in %0d",
                        rh, rl, cyc, W + 2);
    end
    run_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, 1'b1, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== 64'hFFFF_FFFF_FFFF_FFEB || cyc !== W + 2) begin
      fails++; $display("FAIL operand_toggle: got %h_%h in %0d cycles required ffffffff_ffffffeb in %0d",
                        rh, rl, cyc, W + 2);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    start = 1'b1; op = OP_MULTU; rs_data = 32'd3; rt_data = 32'd5;
    n = 0;
    #1;
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if ({hi, lo} !== 64'd15 || n !== W + 2) begin
      fails++; $display("FAIL b2b_first: got %h_%h in %0d cycles required 0_0000000f in %0d", hi, lo, n, W + 2);
    end
    rs_data = 32'd7; rt_data = 32'd9;
    n = 0;
    @(posedge clk); #1;
    n++;
    tests++;
    if ({stall, busy, done} !== 3'b100) begin
      fails++; $display("FAIL b2b_idle_gap: got stall=%b busy=%b done=%b required 1 0 0", stall, busy, done);
    end
    while (done !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    tests++;
    if ({hi, lo} !== 64'd63 || n !== W + 3) begin
      fails++; $display("FAIL b2b_second: got %h_%h %0d cycles after done required 0_0000003f after %0d",
                        hi, lo, n, W + 3);
    end
    start = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_early_term();
    logic [W-1:0] rh, rl; logic rd; int cyc; bit sok;
    run_op(OP_MULTU, 32'd5, 32'd1, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== 64'd5 || cyc !== LAT_5X1) begin
      fails++; $display("FAIL multu_5x1: got %h_%h in %0d cycles required 0_00000005 in %0d",
                        rh, rl, cyc, LAT_5X1);
    end
    run_op(OP_MULTU, 32'd3, 32'd12, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== 64'd36 || cyc !== LAT_3X12 || sok !== 1'b1) begin
      fails++; $display("FAIL multu_3x12: got %h_%h in %0d cycles stall_ok=%b required 0_00000024 in %0d 1",
                        rh, rl, cyc, sok, LAT_3X12);
    end
    run_op(OP_DIVU, 32'd50, 32'd7, 1'b0, rh, rl, rd, cyc, sok);
    tests++;
    if ({rh, rl} !== {32'd1, 32'd7} || cyc !== W + 2) begin
      fails++; $display("FAIL divu_50_7: got hi=%h lo=%h in %0d cycles required 1 7 in %0d",
                        rh, rl, cyc, W + 2);
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed();
    test_div_zero();
    test_div_boundary();
    test_reset_midrun();
    test_back_to_back();
    test_early_term();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
